dmem_arbiter_ctrl: RTL

- Two-port arbiter and access sequencer in front of a byte-wide, single-ported data memory.
- Port 0 is the core load/store unit; port 1 is the debug/DMA port.
- Each granted access is broken into 1, 2 or 4 byte-lane cycles on the memory port.
- Read bytes are assembled little-endian and sign- or zero-extended per RISC-V funct3.

---
 rtl/dmem_arbiter_ctrl_pkg.sv | 41 ++++
 rtl/dmem_arbiter_ctrl_if.sv | 34 +++
 rtl/dmem_arbiter_ctrl_rr_arb2.sv | 24 ++
 rtl/dmem_arbiter_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_ctrl_pkg.sv
// Shared constants, types and helpers for the two-port byte-wide data-memory arbiter.
package dmem_arbiter_ctrl_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // Per-access attributes held for the whole sequence (address kept apart, it is parameterised).
  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] wdata;
  } acc_t;

  function automatic logic [2:0] bytes_for_funct3(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: bytes_for_funct3 = 3'd1;
      F3_LH, F3_LHU: bytes_for_funct3 = 3'd2;
      F3_LW:         bytes_for_funct3 = 3'd4;
      default:       bytes_for_funct3 = 3'd0;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] raw);
    case (f3)
      F3_LB:   load_extend = {{24{raw[7]}}, raw[7:0]};
      F3_LH:   load_extend = {{16{raw[15]}}, raw[15:0]};
      F3_LBU:  load_extend = {24'd0, raw[7:0]};
      F3_LHU:  load_extend = {16'd0, raw[15:0]};
      default: load_extend = raw;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_ctrl_if.sv
// Request/response ports of both requesters plus the byte-wide memory port.
interface dmem_arbiter_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              p0_req, p0_we, p0_gnt, p0_rsp_valid;
  logic [2:0]        p0_funct3;
  logic [ADDR_W-1:0] p0_addr;
  logic [31:0]       p0_wdata;
  logic              p1_req, p1_we, p1_gnt, p1_rsp_valid;
  logic [2:0]        p1_funct3;
  logic [ADDR_W-1:0] p1_addr;
  logic [31:0]       p1_wdata;
  logic              rsp_err;
  logic [31:0]       rsp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we, mem_re;
  logic [7:0]        mem_wdata, mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_funct3, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_funct3, p1_addr, p1_wdata,
    input  mem_rdata,
    output p0_gnt, p0_rsp_valid, p1_gnt, p1_rsp_valid,
    output rsp_err, rsp_rdata, mem_addr, mem_we, mem_re, mem_wdata
  );

  modport master (
    output p0_req, p0_we, p0_funct3, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_funct3, p1_addr, p1_wdata,
    output mem_rdata,
    input  p0_gnt, p0_rsp_valid, p1_gnt, p1_rsp_valid,
    input  rsp_err, rsp_rdata, mem_addr, mem_we, mem_re, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the port that did not win last time is chosen.
module dmem_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt,
  output logic       sel
);
  logic last_grant;

  always_comb begin
    sel = req[1];
    if (req == 2'b11) sel = ~last_grant;
  end

  assign gnt = (req == 2'b00) ? 2'b00 : (sel ? 2'b10 : 2'b01);

  // Reset to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset)                      last_grant <= 1'b1;
    else if (upd && (req != 2'b00)) last_grant <= sel;
  end
endmodule

// File: rtl/dmem_arbiter_ctrl.sv
// Arbitrates two requesters onto a single-ported byte memory and sequences each
// granted access into 1/2/4 byte cycles, assembling loads little-endian.
module dmem_arbiter_ctrl
  import dmem_arbiter_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  dmem_arbiter_ctrl_if.slave bus
);
  logic [1:0]        state;
  logic [1:0]        cnt;
  logic [2:0]        nbytes;
  logic              port;
  acc_t              acc;
  logic [ADDR_W-1:0] base;
  logic [DATA_W-1:0] raw, raw_nxt, rdata_q;
  logic              err_q, rd_vld;
  logic [1:0]        rd_idx;

  logic              idle, upd, sel, req_err, last_beat;
  logic [1:0]        req, arb_gnt;
  logic [2:0]        req_n;
  acc_t              req_acc;
  logic [ADDR_W-1:0] req_addr;

  assign idle = (state == ST_IDLE);
  assign upd  = idle && !reset;
  assign req  = {bus.p1_req, bus.p0_req};

  dmem_rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .upd   (upd),
    .gnt   (arb_gnt),
    .sel   (sel)
  );

  assign bus.p0_gnt = upd && arb_gnt[0];
  assign bus.p1_gnt = upd && arb_gnt[1];

  always_comb begin
    req_acc.we     = sel ? bus.p1_we     : bus.p0_we;
    req_acc.funct3 = sel ? bus.p1_funct3 : bus.p0_funct3;
    req_acc.wdata  = sel ? bus.p1_wdata  : bus.p0_wdata;
    req_addr       = sel ? bus.p1_addr   : bus.p0_addr;
  end

  // Unsigned codes are load-only; a store with them is rejected like an unknown code.
  assign req_n     = bytes_for_funct3(req_acc.funct3);
  assign req_err   = (req_n == 3'd0) || (req_acc.we && req_acc.funct3[2]);
  assign last_beat = ({1'b0, cnt} == (nbytes - 3'd1));

  // Read data returns one cycle after mem_re; merge it into the byte slot it was issued for.
  always_comb begin
    raw_nxt = raw;
    if (rd_vld) raw_nxt[8*rd_idx +: 8] = bus.mem_rdata;
  end

  assign bus.mem_addr     = base + ADDR_W'(cnt);
  assign bus.mem_we       = (state == ST_ACCESS) &&  acc.we;
  assign bus.mem_re       = (state == ST_ACCESS) && !acc.we;
  assign bus.mem_wdata    = acc.wdata[8*cnt +: 8];
  assign bus.rsp_rdata    = rdata_q;
  assign bus.rsp_err      = err_q;
  assign bus.p0_rsp_valid = (state == ST_RESP) && !port;
  assign bus.p1_rsp_valid = (state == ST_RESP) &&  port;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      nbytes  <= '0;
      port    <= 1'b0;
      acc     <= '0;
      base    <= '0;
      raw     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      rd_vld  <= 1'b0;
      rd_idx  <= '0;
    end else begin
      rd_vld <= bus.mem_re;
      rd_idx <= cnt;
      raw    <= raw_nxt;
      case (state)
        ST_IDLE: if (req != 2'b00) begin
          port   <= sel;
          acc    <= req_acc;
          base   <= req_addr;
          nbytes <= req_n;
          cnt    <= '0;
          if (req_err) begin
            state   <= ST_RESP;
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (last_beat) begin
            if (acc.we) begin
              state   <= ST_RESP;
              err_q   <= 1'b0;
              rdata_q <= '0;
            end else begin
              state <= ST_DRAIN;
            end
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        ST_DRAIN: begin
          state   <= ST_RESP;
          err_q   <= 1'b0;
          rdata_q <= load_extend(acc.funct3, raw_nxt);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
